test_scoreboard: RTL and testbench

Downstream consumer of the lab checker's per-test `test`/`result` stream. Accepts one result beat per completed test over a valid/ready handshake. Accumulates pass and fail counts and enforces in-order test indices. Logs failing test indices in a small FIFO for the bench or debug readout, and raises a final `done`/`all_pass` verdict after `NUM_TESTS` beats.

---
 rtl/test_scoreboard.sv | 175 +++++++++++++++++
 tb/tb_test_scoreboard.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/test_scoreboard.sv
// Result scoreboard for the lab checker: counts pass/fail beats, enforces in-order
// test indices, logs failing indices in a small FIFO and reports a final verdict.
module test_scoreboard #(
  parameter int ADDR_W    = 4,
  parameter int NUM_TESTS = 8,
  parameter int LOG_DEPTH = 4,
  parameter int CNT_W     = $clog2(NUM_TESTS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] test,
  input  logic              result,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              done,
  output logic              all_pass,
  output logic              seq_error,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [ADDR_W-1:0] log_index,
  output logic              log_overflow,
  output logic [1:0]        dbg_state
);

  // Handshake: a result beat transfers on a rising edge where in_valid && in_ready;
  // a log entry is popped on a rising edge where log_valid && log_ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_TESTS - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(LOG_DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  fail_q, fail_d;
  logic [ADDR_W-1:0] exp_q, exp_d;
  logic              seq_err_q, seq_err_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] mem_q [LOG_DEPTH];
  logic [ADDR_W-1:0] mem_d [LOG_DEPTH];
  logic [PTR_W:0]    wr_q, wr_d;
  logic [PTR_W:0]    rd_q, rd_d;
  logic [ADDR_W-1:0] head_q, head_d;

  logic              accept;
  logic              in_order;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic [PTR_W:0]    fifo_cnt;
  logic [PTR_W:0]    cnt_next;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    fifo_cnt  = wr_q - rd_q;
    fifo_full = (fifo_cnt == FULL_CNT);
    accept    = (state_q == S_RUN) && in_valid;
    in_order  = (test == exp_q);
    pop       = (fifo_cnt != '0) && log_ready;
    push      = accept && in_order && !result;
  end

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    exp_d     = exp_q;
    seq_err_d = seq_err_q;
    ovf_d     = ovf_q;
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    head_d    = head_q;
    cnt_next  = fifo_cnt;

    if (start) begin
      state_d   = S_RUN;
      pass_d    = '0;
      fail_d    = '0;
      exp_d     = '0;
      seq_err_d = 1'b0;
      ovf_d     = 1'b0;
      wr_d      = '0;
      rd_d      = '0;
      head_d    = '0;
    end else begin
      if (pop) begin
        rd_d = rd_q + (PTR_W + 1)'(1);
      end

      if (accept) begin
        if (in_order) begin
          if (result) begin
            pass_d = pass_q + CNT_W'(1);
          end else begin
            fail_d = fail_q + CNT_W'(1);
          end
          exp_d = exp_q + ADDR_W'(1);
          if ((pass_q + fail_q) == LAST_BEAT) begin
            state_d = S_DONE;
          end
        end else begin
          seq_err_d = 1'b1;
          state_d   = S_ERR;
        end
      end

      // A same-cycle pop frees the slot the push is about to use.
      if (push) begin
        if (!fifo_full || pop) begin
          mem_d[wr_q[PTR_W-1:0]] = test;
          wr_d                   = wr_q + (PTR_W + 1)'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end

      cnt_next = wr_d - rd_d;
      if (cnt_next != '0) begin
        head_d = mem_d[rd_d[PTR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pass_q    <= '0;
      fail_q    <= '0;
      exp_q     <= '0;
      seq_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      head_q    <= '0;
      for (int i = 0; i < LOG_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      exp_q     <= exp_d;
      seq_err_q <= seq_err_d;
      ovf_q     <= ovf_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      head_q    <= head_d;
      mem_q     <= mem_d;
    end
  end

  always_comb begin
    in_ready     = (state_q == S_RUN);
    done         = (state_q == S_DONE);
    all_pass     = (state_q == S_DONE) && (fail_q == '0) && !seq_err_q;
    pass_count   = pass_q;
    fail_count   = fail_q;
    seq_error    = seq_err_q;
    log_valid    = (fifo_cnt != '0);
    log_index    = head_q;
    log_overflow = ovf_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_test_scoreboard.sv
// Randomized and directed bench for test_scoreboard, checked cycle by cycle
// against a queue-based reference model of the scoreboard rules.
module tb_test_scoreboard;

  localparam int ADDR_W    = 4;
  localparam int NUM_TESTS = 8;
  localparam int LOG_DEPTH = 4;
  localparam int CNT_W     = $clog2(NUM_TESTS + 1);

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [ADDR_W-1:0] test = '0;
  logic              result = 1'b0;
  logic              log_ready = 1'b0;
  logic              in_ready;
  logic [CNT_W-1:0]  pass_count;
  logic [CNT_W-1:0]  fail_count;
  logic              done;
  logic              all_pass;
  logic              seq_error;
  logic              log_valid;
  logic [ADDR_W-1:0] log_index;
  logic              log_overflow;
  logic [1:0]        dbg_state;

  test_scoreboard #(
    .ADDR_W(ADDR_W), .NUM_TESTS(NUM_TESTS), .LOG_DEPTH(LOG_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .test(test), .result(result),
    .pass_count(pass_count), .fail_count(fail_count),
    .done(done), .all_pass(all_pass), .seq_error(seq_error),
    .log_valid(log_valid), .log_ready(log_ready), .log_index(log_index),
    .log_overflow(log_overflow), .dbg_state(dbg_state)
  );

  // reference model: mode 0 idle, 1 run, 2 done, 3 err
  int                m_mode, m_pass, m_fail, m_exp;
  bit                m_seq, m_ovf;
  logic [ADDR_W-1:0] m_head;
  logic [ADDR_W-1:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pass = 0; m_fail = 0; m_exp = 0;
    m_seq = 0; m_ovf = 0; m_head = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit pop_now;
    bit push_req;
    if (!reset) begin
      model_reset();
      return;
    end
    if (start) begin
      model_reset();
      m_mode = 1;
      return;
    end
    pop_now  = log_ready && (exp_q.size() > 0);
    push_req = 0;
    if (m_mode == 1 && in_valid) begin
      if (int'(test) == m_exp) begin
        if (result) m_pass++;
        else begin
          m_fail++;
          push_req = 1;
        end
        m_exp++;
        if (m_pass + m_fail == NUM_TESTS) m_mode = 2;
      end else begin
        m_seq  = 1;
        m_mode = 3;
      end
    end
    if (pop_now) void'(exp_q.pop_front());
    if (push_req) begin
      if (exp_q.size() < LOG_DEPTH) exp_q.push_back(test);
      else m_ovf = 1;
    end
    if (exp_q.size() > 0) m_head = exp_q[0];
  endtask

  task automatic check_all();
    check("in_ready", in_ready, m_mode == 1);
    check("pass_count", pass_count, m_pass);
    check("fail_count", fail_count, m_fail);
    check("done", done, m_mode == 2);
    check("all_pass", all_pass, (m_mode == 2) && (m_fail == 0));
    check("seq_error", seq_error, m_seq);
    check("log_valid", log_valid, exp_q.size() > 0);
    check("log_index", log_index, m_head);
    check("log_overflow", log_overflow, m_ovf);
    check("state", dbg_state, m_mode);
  endtask

  // driver: inputs change #1 after a rising edge, outputs sampled #1 after the next
  task automatic drive(input bit st, input bit v, input int t, input bit r, input bit pop);
    start     = st;
    in_valid  = v;
    test      = t[ADDR_W-1:0];
    result    = r;
    log_ready = pop;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;

    // beats offered in IDLE are ignored
    for (int i = 0; i < 3; i++) drive(0, 1, i, 1, 0);
    check("idle_pass", pass_count, 0);

    // clean run with in_valid held high
    drive(1, 0, 0, 0, 0);
    check("start_ready", in_ready, 1);
    for (int i = 0; i < NUM_TESTS; i++) drive(0, 1, i, 1, 0);
    check("clean_pass", pass_count, 8);
    check("clean_fail", fail_count, 0);
    check("clean_done", done, 1);
    check("clean_allpass", all_pass, 1);
    check("clean_logvalid", log_valid, 0);
    for (int i = 0; i < 2; i++) drive(0, 1, 8, 1, 0);
    check("after_done_pass", pass_count, 8);

    // failures at 2 and 5 are logged
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < NUM_TESTS; i++) drive(0, 1, i, !(i == 2 || i == 5), 0);
    check("fl_fail", fail_count, 2);
    check("fl_pass", pass_count, 6);
    check("fl_allpass", all_pass, 0);
    check("fl_head0", log_index, 2);
    drive(0, 0, 0, 0, 1);
    check("fl_head1", log_index, 5);
    drive(0, 0, 0, 0, 1);
    check("fl_empty", log_valid, 0);

    // overflow: six failing beats, no pops
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, i, 0, 0);
    check("ov_flag", log_overflow, 1);
    check("ov_fail", fail_count, 6);
    for (int k = 0; k < 4; k++) begin
      check("ov_entry", log_index, k);
      drive(0, 0, 0, 0, 1);
    end
    check("ov_empty", log_valid, 0);

    // pop coinciding with the fifth failing beat prevents overflow
    drive(1, 0, 0, 0, 0);
    check("restart_ovf_clr", log_overflow, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, i, 0, i == 4);
    check("ovp_flag", log_overflow, 0);
    for (int k = 1; k <= 4; k++) begin
      check("ovp_entry", log_index, k);
      drive(0, 0, 0, 0, 1);
    end
    check("ovp_empty", log_valid, 0);

    // sequence error: 0, 1, then 3
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0);
    drive(0, 1, 1, 1, 0);
    drive(0, 1, 3, 1, 0);
    check("se_flag", seq_error, 1);
    check("se_state", dbg_state, 3);
    check("se_ready", in_ready, 0);
    check("se_pass", pass_count, 2);
    check("se_done", done, 0);
    drive(1, 0, 0, 0, 0);
    check("se_clear", seq_error, 0);
    check("se_ready_again", in_ready, 1);

    // gaps in in_valid mid-run
    for (int i = 0; i < NUM_TESTS; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) drive(0, 0, $urandom_range(0, 15), 0, 0);
      drive(0, 1, i, 1, 0);
    end
    check("gap_pass", pass_count, 8);
    check("gap_done", done, 1);

    // asynchronous reset mid-run
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, i, i != 1, 0);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_pass", pass_count, 0);
    drive(0, 1, 3, 1, 0);
    reset = 1'b1;
    idle(2);
    check("rst_idle", dbg_state, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < NUM_TESTS; i++) drive(0, 1, i, 1, 0);
    check("rst_rerun_pass", pass_count, 8);

    // randomized runs
    for (int run = 0; run < 40; run++) begin
      drive(1, 0, 0, 0, 0);
      for (int c = 0; c < 30; c++) begin
        bit st, v, r, pop;
        int t;
        st  = ($urandom_range(0, 59) == 0);
        v   = ($urandom_range(0, 9) < 7);
        t   = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 15) : m_exp;
        r   = ($urandom_range(0, 2) != 0);
        pop = ($urandom_range(0, 3) == 0);
        drive(st, v, t, r, pop);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
